// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with a two-entry skid buffer and registered in_ready.
// Optional stall counter output enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int RSRC_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   ALU_Result,
  input  logic [XLEN-1:0]   RD2E,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [REG_AW-1:0] rdE,
  input  logic              MemWriteE,
  input  logic              RegWriteE,
  input  logic [RSRC_W-1:0] ResultSrcE,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   ALU_ResultM,
  output logic [XLEN-1:0]   writedataM,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [REG_AW-1:0] rdM,
  output logic              MemWriteM,
  output logic              RegWriteM,
  output logic [RSRC_W-1:0] ResultSrcM
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   wd;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic              mw;
    logic              rw;
    logic [RSRC_W-1:0] rs;
  } ent_t;

  ent_t in_e;
  ent_t out_q, out_d;
  ent_t skd_q, skd_d;
  logic out_v_q, out_v_d;
  logic skd_v_q, skd_v_d;
  logic rdy_q;
  logic acc;
  logic free;

  assign in_e = '{
    alu: ALU_Result,
    wd:  RD2E,
    pc:  PCPlus4E,
    rd:  rdE,
    mw:  MemWriteE,
    rw:  RegWriteE,
    rs:  ResultSrcE
  };

  assign acc  = in_valid & rdy_q;
  assign free = ~out_v_q | out_ready;

  always_comb begin
    out_d   = out_q;
    skd_d   = skd_q;
    out_v_d = out_v_q;
    skd_v_d = skd_v_q;
    if (flush) begin
      out_v_d = 1'b0;
      skd_v_d = 1'b0;
    end else if (free) begin
      if (skd_v_q) begin
        out_d   = skd_q;
        out_v_d = 1'b1;
        skd_v_d = acc;
        if (acc) skd_d = in_e;
      end else begin
        out_v_d = acc;
        if (acc) out_d = in_e;
      end
    end else if (acc) begin
      skd_d   = in_e;
      skd_v_d = 1'b1;
    end
  end

  // in_ready comes straight from its own flop, so out_ready never reaches it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      skd_q   <= '0;
      out_v_q <= 1'b0;
      skd_v_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      out_q   <= out_d;
      skd_q   <= skd_d;
      out_v_q <= out_v_d;
      skd_v_q <= skd_v_d;
      rdy_q   <= ~skd_v_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = out_v_q;
  assign ALU_ResultM = out_q.alu;
  assign writedataM  = out_q.wd;
  assign PCPlus4M    = out_q.pc;
  assign rdM         = out_q.rd;
  assign MemWriteM   = out_q.mw & out_v_q;
  assign RegWriteM   = out_q.rw & out_v_q;
  assign ResultSrcM  = out_q.rs;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_v_q && !out_ready && cnt_q != 32'hFFFF_FFFF) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: queue-based reference model,
// directed scenarios followed by randomized traffic with flushes and resets.
module tb_ex_mem_pipe;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        mw;
    logic        rw;
    logic [1:0]  rs;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ALU_Result, RD2E, PCPlus4E;
  logic [4:0]  rdE;
  logic        MemWriteE, RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALU_ResultM, writedataM, PCPlus4M;
  logic [4:0]  rdM;
  logic        MemWriteM, RegWriteM;
  logic [1:0]  ResultSrcM;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALU_Result(ALU_Result), .RD2E(RD2E), .PCPlus4E(PCPlus4E),
    .rdE(rdE), .MemWriteE(MemWriteE), .RegWriteE(RegWriteE),
    .ResultSrcE(ResultSrcE),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_ResultM(ALU_ResultM), .writedataM(writedataM),
    .PCPlus4M(PCPlus4M), .rdM(rdM),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM)
`ifdef EX_MEM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  ent_t q[$];
  ent_t last;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares what the DUT presents against the model queue head
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      if (out_valid && q.size() > 0) last = q[0];
      chk("ALU_ResultM", ALU_ResultM, last.alu);
      chk("writedataM", writedataM, last.wd);
      chk("PCPlus4M", PCPlus4M, last.pc);
      chk("rdM", {27'd0, rdM}, {27'd0, last.rd});
      chk("ResultSrcM", {30'd0, ResultSrcM}, {30'd0, last.rs});
      chk("MemWriteM", {31'd0, MemWriteM},
          {31'd0, out_valid && last.mw});
      chk("RegWriteM", {31'd0, RegWriteM},
          {31'd0, out_valid && last.rw});
      if (!rst && !flush && out_valid && out_ready && q.size() > 0)
        void'(q.pop_front());
      if (rst) last = '{default: '0};
    end
  end

  function automatic ent_t rnd_ent();
    ent_t e;
    e.alu = $urandom;
    e.wd  = $urandom;
    e.pc  = $urandom;
    e.rd  = 5'($urandom);
    e.mw  = 1'($urandom);
    e.rw  = 1'($urandom);
    e.rs  = 2'($urandom);
    return e;
  endfunction

  // One cycle of stimulus; the driver owns pushes and flush/reset clears
  task automatic cyc(input bit v, input bit f, input bit r,
                     input ent_t e, input bit rs_i);
    rst        = rs_i;
    flush      = f;
    in_valid   = v;
    out_ready  = r;
    ALU_Result = e.alu;
    RD2E       = e.wd;
    PCPlus4E   = e.pc;
    rdE        = e.rd;
    MemWriteE  = e.mw;
    RegWriteE  = e.rw;
    ResultSrcE = e.rs;
    @(negedge clk);
    #1;
    if (rs_i || f) q.delete();
    else if (v && in_ready) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  ent_t z;
  ent_t e;

  initial begin
    z = '{default: '0};
    last = z;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALU_Result = '0; RD2E = '0; PCPlus4E = '0; rdE = '0;
    MemWriteE = 1'b0; RegWriteE = 1'b0; ResultSrcE = '0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, z, 1);
    mon_en = 1;
    chk("reset ALU_ResultM", ALU_ResultM, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);

    // single entry, next-cycle latency
    e = z; e.alu = 32'hA5; e.rd = 5'd7; e.rw = 1'b1;
    cyc(1, 0, 1, e, 0);
    chk("lat out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat ALU_ResultM", ALU_ResultM, 32'hA5);
    chk("lat rdM", {27'd0, rdM}, 32'd7);
    chk("lat RegWriteM", {31'd0, RegWriteM}, 32'd1);
    cyc(0, 0, 1, z, 0);

    // back-to-back stream at full throughput
    for (int i = 1; i <= 8; i++) begin
      e = z; e.alu = i; e.rw = 1'b1;
      cyc(1, 0, 1, e, 0);
      chk("stream value", ALU_ResultM, i);
    end
    cyc(0, 0, 1, z, 0);

    // back-pressure fills OUT then SKD
    e = z; e.alu = 32'hAAAA; cyc(1, 0, 0, e, 0);
    e = z; e.alu = 32'hBBBB; cyc(1, 0, 0, e, 0);
    chk("bp in_ready", {31'd0, in_ready}, 32'd0);
    e = z; e.alu = 32'hCCCC; cyc(1, 0, 0, e, 0);
    cyc(0, 0, 1, z, 0);
    chk("bp A->B", ALU_ResultM, 32'hBBBB);
    chk("bp ready after drain", {31'd0, in_ready}, 32'd1);
    cyc(0, 0, 1, z, 0);

    // flush with both entries full and a store offered
    e = z; e.alu = 32'h1; e.rw = 1'b1; cyc(1, 0, 0, e, 0);
    e = z; e.alu = 32'h2; e.rw = 1'b1; cyc(1, 0, 0, e, 0);
    e = z; e.alu = 32'hDEAD; e.mw = 1'b1; cyc(1, 1, 0, e, 0);
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush MemWriteM", {31'd0, MemWriteM}, 32'd0);
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, z, 0);

    // reset mid-transfer
    cyc(1, 0, 0, rnd_ent(), 0);
    cyc(1, 0, 0, rnd_ent(), 0);
    cyc(1, 0, 0, rnd_ent(), 1);
    chk("rst mid out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst mid PCPlus4M", PCPlus4M, 32'd0);

`ifdef EX_MEM_STALL_CNT_EN
    cyc(1, 0, 0, rnd_ent(), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, z, 0);
    cyc(0, 1, 1, z, 0);
    chk("stall_cnt", stall_cnt, 32'd5);
    cyc(0, 0, 1, z, 0);
    chk("stall_cnt hold", stall_cnt, 32'd5);
    cyc(0, 0, 0, z, 1);
    chk("stall_cnt rst", stall_cnt, 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          $urandom_range(0, 40) == 0,
          1'($urandom_range(0, 2) != 0),
          rnd_ent(),
          $urandom_range(0, 200) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, z, 0);
    chk("drained", {31'd0, out_valid}, 32'd0);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  XLEN  32  datapath width
  REG_AW  5  register-address width
  RSRC_W  2  result-select width
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  sole clock, all state updates on rising edge
  rst  in  1  reset, synchronous, active-high
  flush  in  1  discard all held and incoming entries
  in_valid  in  1  EX stage presents an entry
  in_ready  out  1  stage can accept an entry
  ALU_Result  in  XLEN  EX ALU result
  RD2E  in  XLEN  store data
  PCPlus4E  in  XLEN  PC+4
  rdE  in  REG_AW  destination register
  MemWriteE  in  1  store enable
  RegWriteE  in  1  writeback enable
  ResultSrcE  in  RSRC_W  writeback mux select
  out_valid  out  1  MEM-side entry valid
  out_ready  in  1  MEM stage consumes the entry
  ALU_ResultM, writedataM, PCPlus4M  out  XLEN  registered copies of ALU_Result, RD2E, PCPlus4E
  rdM  out  REG_AW; MemWriteM, RegWriteM  out  1; ResultSrcM  out  RSRC_W  registered copies
REQ-003 One clock; reset is synchronous and active-high (clk, rst).

Function
REQ-004 Two entries: output register (OUT, drives the *M ports) and skid register (SKD); each has a valid bit.
REQ-005 in_ready = !SKD.valid, driven directly from a flop with no combinational path from out_ready.
REQ-006 Accept = in_valid && in_ready; the entry is captured at that clock edge.
REQ-007 OUT drains when out_valid && out_ready; out_valid = OUT.valid.
REQ-008 At an edge where OUT is empty or draining: OUT loads SKD if SKD.valid, else the accepted entry; if SKD was moved and an entry is also accepted, that entry goes to SKD.
REQ-009 At an edge where OUT is full and not draining, an accepted entry goes to SKD.
REQ-010 Latency: an entry accepted into an empty stage appears on the *M ports the next cycle; with out_ready held high, sustained throughput is 1 entry/cycle.
REQ-011 Entries leave in acceptance order; none are duplicated or dropped (except on flush).
REQ-012 Bubble rule: whenever out_valid=0, MemWriteM=0 and RegWriteM=0; the other *M outputs hold their last values.
REQ-013 flush=1: both valid bits clear at the edge, the entry offered in the same cycle is discarded, and in_ready=1 on the following cycle.
REQ-014 flush has priority over accept and drain; rst has priority over flush.
REQ-015 SKD contents are not visible on any output.

Reset
REQ-016 rst=1 at an edge: OUT.valid=0, SKD.valid=0, all *M outputs=0, in_ready=1 from the next cycle.
REQ-017 rst asserted mid-transfer discards every held entry; no *M control bit is 1 in the cycle after reset.

Configuration
REQ-018 Macro EX_MEM_STALL_CNT_EN defined: adds output stall_cnt (32 bits); it increments on each cycle with out_valid && !out_ready, saturates at 0xFFFFFFFF, is cleared by rst, and is not cleared by flush.
REQ-019 Macro EX_MEM_STALL_CNT_EN not defined: port stall_cnt and its logic are absent; all other behaviour is identical.

Verification
REQ-020 rst, then in_valid=1 with ALU_Result=0x0000_00A5, rdE=7, RegWriteE=1, out_ready=1 -> next cycle out_valid=1, ALU_ResultM=0x0000_00A5, rdM=7, RegWriteM=1.
REQ-021 Stream values 1..8 on consecutive cycles with out_ready=1 -> outputs show 1..8 on consecutive cycles, in_ready stays 1.
REQ-022 out_ready=0 while sending A then B -> in_ready=0 after B; raise out_ready -> A then B delivered in order, in_ready=1 one cycle after the SKD drain.
REQ-023 OUT and SKD full, MemWriteE=1 offered, flush=1 -> next cycle out_valid=0, MemWriteM=0, RegWriteM=0, in_ready=1, offered entry never appears.
REQ-024 With EX_MEM_STALL_CNT_EN defined: out_valid=1, out_ready=0 for 5 cycles, then flush -> stall_cnt=5 and remains 5.
